alu_multicycle: RTL and testbench

Parametrised, registered successor to the CPU's combinational ALU.
- Keeps the existing 4-bit opcode map for single-cycle operations.
- Fills the reserved codes with iterative multiply and unsigned divide, executed one bit per cycle.
- Sits in the EX stage. The control unit issues `start` and stalls on `busy` until `done` pulses with a registered result.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/muldiv_iter.sv | 55 +++++
 rtl/alu_multicycle.sv | 143 ++++++++++++++
 tb/tb_alu_multicycle.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification for the multicycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_OR      = 4'b0000;
  localparam logic [3:0] OP_AND     = 4'b0001;
  localparam logic [3:0] OP_XOR     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_SHIFTL  = 4'b0101;
  localparam logic [3:0] OP_SHIFTR  = 4'b0110;
  localparam logic [3:0] OP_NOTA    = 4'b0111;
  localparam logic [3:0] OP_MUL     = 4'b1000;
  localparam logic [3:0] OP_MULHU   = 4'b1001;
  localparam logic [3:0] OP_SLT     = 4'b1010;
  localparam logic [3:0] OP_SLTU    = 4'b1011;
  localparam logic [3:0] OP_LOAD    = 4'b1100;
  localparam logic [3:0] OP_LOADHI  = 4'b1101;
  localparam logic [3:0] OP_SHIFTRS = 4'b1110;
  localparam logic [3:0] OP_DIVU    = 4'b1111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-step shift-add multiplier / restoring divider sharing one register set.
// Outputs are the values the registers take after the next step, so the final step's result is usable on the step edge.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  // hi: product high half / partial remainder; lo: multiplier / dividend-quotient; opnd: multiplicand / divisor
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    addend  = lo[0] ? opnd : '0;
    msum    = {1'b0, hi} + {1'b0, addend};
    prod_hi = msum[WIDTH:1];
    prod_lo = {msum[0], lo[WIDTH-1:1]};

    shifted = {hi, lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd});
    diff    = shifted[WIDTH-1:0] - opnd;
    rem     = ge ? diff : shifted[WIDTH-1:0];
    quot    = {lo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
    end else if (load) begin
      hi   <= '0;
      lo   <= mode ? a : b;
      opnd <= mode ? b : a;
    end else if (step) begin
      hi <= mode ? rem  : prod_hi;
      lo <= mode ? quot : prod_lo;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle ops complete in one cycle, MUL/MULHU/DIVU iterate one bit per cycle.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CW   = $clog2(WIDTH + 1);

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             hi_sel, hi_sel_nx;
  logic [WIDTH-1:0] y_nx, rem_nx;
  logic             done_nx, busy_nx;
  logic             load_c, step_c, mode_c;
  logic [WIDTH-1:0] sc_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] md_lo, md_hi, md_quot, md_rem;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .load    (load_c),
    .mode    (mode_c),
    .step    (step_c),
    .a       (a),
    .b       (b),
    .prod_lo (md_lo),
    .prod_hi (md_hi),
    .quot    (md_quot),
    .rem     (md_rem)
  );

  assign shamt = b[SHW-1:0];

  // Single-cycle result mux
  always_comb begin
    sc_res = '0;
    case (opcode)
      OP_OR:      sc_res = a | b;
      OP_AND:     sc_res = a & b;
      OP_XOR:     sc_res = a ^ b;
      OP_ADD:     sc_res = a + b;
      OP_SUB:     sc_res = a - b;
      OP_SHIFTL:  sc_res = a << shamt;
      OP_SHIFTR:  sc_res = a >> shamt;
      OP_NOTA:    sc_res = ~a;
      OP_SLT:     sc_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU:    sc_res = WIDTH'(a < b);
      OP_LOAD:    sc_res = b;
      OP_LOADHI:  sc_res = {b[HALF-1:0], a[HALF-1:0]};
      OP_SHIFTRS: sc_res = WIDTH'($signed(a) >>> shamt);
      default:    sc_res = '0;
    endcase
  end

  // Next-state and next-output logic; flush outranks everything
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hi_sel_nx = hi_sel;
    y_nx      = y;
    rem_nx    = rem;
    done_nx   = 1'b0;
    load_c    = 1'b0;
    step_c    = 1'b0;
    mode_c    = (state == DIV);
    case (state)
      IDLE: begin
        mode_c = (opcode == OP_DIVU);
        if (start && !flush) begin
          if (is_multicycle(opcode)) begin
            load_c    = 1'b1;
            cnt_nx    = CW'(WIDTH);
            hi_sel_nx = (opcode == OP_MULHU);
            state_nx  = (opcode == OP_DIVU) ? DIV : MUL;
          end else begin
            y_nx    = sc_res;
            rem_nx  = '0;
            done_nx = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          step_c = 1'b1;
          cnt_nx = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            if (state == DIV) begin
              y_nx   = md_quot;
              rem_nx = md_rem;
            end else begin
              y_nx   = hi_sel ? md_hi : md_lo;
              rem_nx = '0;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_sel <= 1'b0;
      y      <= '0;
      rem    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      hi_sel <= hi_sel_nx;
      y      <= y_nx;
      rem    <= rem_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=16.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, flush;
  logic [3:0]  opcode;
  logic [31:0] a, b, y, rem;
  logic        busy, done;

  logic        start16, flush16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, y16, rem16;
  logic        busy16, done16;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int hits;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .opcode(opcode),
    .a(a), .b(b), .y(y), .rem(rem), .busy(busy), .done(done)
  );

  alu_multicycle #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(start16), .flush(flush16), .opcode(op16),
    .a(a16), .b(b16), .y(y16), .rem(rem16), .busy(busy16), .done(done16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
    opcode = op; a = aa; b = bb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] op, input logic [15:0] aa, input logic [15:0] bb);
    op16 = op; a16 = aa; b16 = bb; start16 = 1'b1;
    tick();
    start16 = 1'b0;
  endtask

  // c counts clock edges since the start edge, bounded
  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 100) begin
      tick();
      c++;
    end
  endtask

  task automatic wait_done16(output int c);
    c = 1;
    while (!done16 && c < 100) begin
      tick();
      c++;
    end
  endtask

  logic [3:0]  t_op [9] = '{OP_SUB, OP_SLT, OP_SLTU, OP_SHIFTRS, OP_SHIFTL,
                            OP_LOADHI, OP_NOTA, OP_LOAD, OP_XOR};
  logic [31:0] t_a  [9] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1,
                            32'h1234_5678, 32'h0F0F_0F0F, 32'h0, 32'hFF00_FF00};
  logic [31:0] t_b  [9] = '{32'd7, 32'h1, 32'h1, 32'h24, 32'h21,
                            32'h0000_ABCD, 32'h0, 32'h5A5A, 32'h0F0F_0F0F};
  logic [31:0] t_y  [9] = '{32'hFFFF_FFFE, 32'h1, 32'h0, 32'hF800_0000, 32'h2,
                            32'hABCD_5678, 32'hF0F0_F0F0, 32'h5A5A, 32'hF00F_F00F};

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; opcode = '0; a = '0; b = '0;
    start16 = 1'b0; flush16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    tick();
    tick();
    check("rst_y", y, 32'h0);
    check("rst_rem", rem, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    tick();

    // single-cycle ADD wrap
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    check("add_done", 32'(done), 32'h1);
    check("add_y", y, 32'h0);
    check("add_busy", 32'(busy), 32'h0);
    tick();
    check("add_done_pulse", 32'(done), 32'h0);

    for (int i = 0; i < 9; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      check($sformatf("single_%0d_done", i), 32'(done), 32'h1);
      check($sformatf("single_%0d_y", i), y, t_y[i]);
      check($sformatf("single_%0d_rem", i), rem, 32'h0);
    end

    // iterative multiply
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    check("mul_busy", 32'(busy), 32'h1);
    check("mul_done_early", 32'(done), 32'h0);
    wait_done(cyc);
    check("mul_lat", 32'(cyc), 32'd33);
    check("mul_y", y, 32'h0);
    check("mul_busy_at_done", 32'(busy), 32'h0);
    issue(OP_MULHU, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc);
    check("mulhu_lat", 32'(cyc), 32'd33);
    check("mulhu_y", y, 32'h1);
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    check("mul_max_y", y, 32'h1);
    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    check("mulhu_max_y", y, 32'hFFFF_FFFE);
    issue(OP_MUL, 32'd7, 32'd6);
    wait_done(cyc);
    check("mul_small_y", y, 32'd42);
    check("mul_small_rem", rem, 32'h0);

    // unsigned divide
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc);
    check("divu_lat", 32'(cyc), 32'd33);
    check("divu_y", y, 32'd14);
    check("divu_rem", rem, 32'd2);
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(cyc);
    check("div0_lat", 32'(cyc), 32'd33);
    check("div0_y", y, 32'hFFFF_FFFF);
    check("div0_rem", rem, 32'd5);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    wait_done(cyc);
    check("divbig_y", y, 32'h1);
    check("divbig_rem", rem, 32'h1);

    // start while busy is ignored
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (8) tick();
    opcode = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_done", 32'(done), 32'h0);
    check("ign_busy", 32'(busy), 32'h1);
    cyc = 10;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check("ign_lat", 32'(cyc), 32'd33);
    check("ign_y", y, 32'd14);
    check("ign_rem", rem, 32'd2);

    // back-to-back issue on the done cycle
    issue(OP_ADD, 32'd2, 32'd3);
    check("b2b_done", 32'(done), 32'h1);
    check("b2b_y", y, 32'd5);
    check("b2b_rem", rem, 32'h0);

    // flush mid-multiply
    issue(OP_MUL, 32'd3, 32'd3);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_done", 32'(done), 32'h0);
    check("flush_y", y, 32'd5);
    hits = 0;
    repeat (40) begin
      tick();
      if (done) hits++;
    end
    check("flush_no_done", 32'(hits), 32'h0);

    // flush suppresses start in IDLE
    opcode = OP_ADD; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_idle_done", 32'(done), 32'h0);
    check("flush_idle_y", y, 32'd5);
    check("flush_idle_busy", 32'(busy), 32'h0);

    // asynchronous reset mid-divide
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("mrst_y", y, 32'h0);
    check("mrst_rem", rem, 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b0;
    hits = 0;
    repeat (40) begin
      tick();
      if (done || busy) hits++;
    end
    check("mrst_quiet", 32'(hits), 32'h0);
    issue(OP_ADD, 32'd1, 32'd2);
    check("mrst_alive_y", y, 32'd3);

    // WIDTH=16 instance
    issue16(OP_SHIFTRS, 16'h8000, 16'h0013);
    check("w16_srs_done", 32'(done16), 32'h1);
    check("w16_srs_y", 32'(y16), 32'h0000_F000);
    issue16(OP_LOADHI, 16'h1234, 16'h00AB);
    check("w16_loadhi_y", 32'(y16), 32'h0000_AB34);
    issue16(OP_DIVU, 16'd1000, 16'd33);
    wait_done16(cyc);
    check("w16_div_lat", 32'(cyc), 32'd17);
    check("w16_div_y", 32'(y16), 32'd30);
    check("w16_div_rem", 32'(rem16), 32'd10);
    issue16(OP_MULHU, 16'hFFFF, 16'hFFFF);
    wait_done16(cyc);
    check("w16_mulhu_y", 32'(y16), 32'h0000_FFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
